// File: rtl/cprv_mem_stage.sv
// Memory stage of the CPRV pipeline: issues one data-memory access per load/store,
// aligns load data, and forwards every instruction to writeback in program order.
module cprv_mem_stage #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  valid_mem_i,
   output logic                  ready_mem_o,
   input  logic [DATA_WIDTH-1:0] alu_out_mem_i,
   input  logic [DATA_WIDTH-1:0] rs2_data_mem_i,
   input  logic [4:0]            rd_addr_mem_i,
   input  logic                  rd_en_mem_i,
   input  logic [6:0]            opcode_mem_i,
   input  logic [2:0]            funct3_mem_i,
   input  logic                  mem_w_en_mem_i,
   output logic                  dmem_req_o,
   input  logic                  dmem_gnt_i,
   output logic                  dmem_we_o,
   output logic [ADDR_WIDTH-1:0] dmem_addr_o,
   output logic [7:0]            dmem_be_o,
   output logic [DATA_WIDTH-1:0] dmem_wdata_o,
   input  logic                  dmem_rvalid_i,
   input  logic [DATA_WIDTH-1:0] dmem_rdata_i,
   output logic                  valid_wb_o,
   input  logic                  ready_wb_i,
   output logic [4:0]            rd_addr_wb_o,
   output logic                  rd_en_wb_o,
   output logic [DATA_WIDTH-1:0] rd_data_wb_o
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_REQ    = 2'd1;
   localparam logic [1:0] S_WAIT   = 2'd2;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;

   logic [1:0]            r_state;
   logic [2:0]            r_off;
   logic [2:0]            r_funct3;
   logic [4:0]            r_rdAddr;
   logic                  r_rdEn;

   logic                  w_accept;
   logic                  w_isStore;
   logic                  w_isLoad;
   logic                  w_isMem;
   logic [2:0]            w_off;
   logic [7:0]            w_be;
   logic [DATA_WIDTH-1:0] w_shifted;
   logic [DATA_WIDTH-1:0] w_loadData;
   logic                  w_nonMemDone;
   logic                  w_storeDone;
   logic                  w_loadDone;
   logic                  w_wbLoad;
   logic [DATA_WIDTH-1:0] w_wbData;
   logic [4:0]            w_wbAddr;
   logic                  w_wbEn;

   // New work is taken only when idle and the WB slot is empty or draining this cycle.
   assign ready_mem_o  = (r_state == S_IDLE) & (~valid_wb_o | ready_wb_i);
   assign dmem_req_o   = (r_state == S_REQ);
   assign w_accept     = valid_mem_i & ready_mem_o;
   assign w_isStore    = (opcode_mem_i == OP_STORE) | mem_w_en_mem_i;
   assign w_isLoad     = (opcode_mem_i == OP_LOAD) & ~w_isStore;
   assign w_isMem      = w_isLoad | w_isStore;
   assign w_off        = alu_out_mem_i[2:0];

   // Misaligned lanes that spill past the doubleword are simply shifted out of the byte mask.
   always_comb begin
      w_be = 8'h00;
      case (funct3_mem_i[1:0])
         2'b00:   w_be = 8'h01 << w_off;
         2'b01:   w_be = 8'h03 << w_off;
         2'b10:   w_be = 8'h0F << w_off;
         default: w_be = 8'hFF;
      endcase
   end

   assign w_shifted = dmem_rdata_i >> {r_off, 3'b000};

   always_comb begin
      w_loadData = w_shifted;
      case (r_funct3)
         3'b000:  w_loadData = {{(DATA_WIDTH-8){w_shifted[7]}}, w_shifted[7:0]};
         3'b001:  w_loadData = {{(DATA_WIDTH-16){w_shifted[15]}}, w_shifted[15:0]};
         3'b010:  w_loadData = {{(DATA_WIDTH-32){w_shifted[31]}}, w_shifted[31:0]};
         3'b100:  w_loadData = {{(DATA_WIDTH-8){1'b0}}, w_shifted[7:0]};
         3'b101:  w_loadData = {{(DATA_WIDTH-16){1'b0}}, w_shifted[15:0]};
         3'b110:  w_loadData = {{(DATA_WIDTH-32){1'b0}}, w_shifted[31:0]};
         default: w_loadData = w_shifted;
      endcase
   end

   assign w_nonMemDone = w_accept & ~w_isMem;
   assign w_storeDone  = (r_state == S_REQ) & dmem_gnt_i & dmem_we_o;
   assign w_loadDone   = (r_state == S_WAIT) & dmem_rvalid_i;
   assign w_wbLoad     = w_nonMemDone | w_storeDone | w_loadDone;

   always_comb begin
      w_wbData = alu_out_mem_i;
      w_wbAddr = rd_addr_mem_i;
      w_wbEn   = rd_en_mem_i;
      if (w_storeDone) begin
         w_wbData = '0;
         w_wbAddr = r_rdAddr;
         w_wbEn   = 1'b0;
      end else if (w_loadDone) begin
         w_wbData = w_loadData;
         w_wbAddr = r_rdAddr;
         w_wbEn   = r_rdEn;
      end
   end

   // Request fields are captured once at accept and held until the access completes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_off        <= 3'd0;
         r_funct3     <= 3'd0;
         r_rdAddr     <= 5'd0;
         r_rdEn       <= 1'b0;
         dmem_we_o    <= 1'b0;
         dmem_addr_o  <= '0;
         dmem_be_o    <= 8'h00;
         dmem_wdata_o <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept & w_isMem) begin
                  r_state      <= S_REQ;
                  r_off        <= w_off;
                  r_funct3     <= funct3_mem_i;
                  r_rdAddr     <= rd_addr_mem_i;
                  r_rdEn       <= rd_en_mem_i;
                  dmem_we_o    <= w_isStore;
                  dmem_addr_o  <= {alu_out_mem_i[ADDR_WIDTH-1:3], 3'b000};
                  dmem_be_o    <= w_be;
                  dmem_wdata_o <= rs2_data_mem_i << {w_off, 3'b000};
               end
            end
            S_REQ: begin
               if (dmem_gnt_i) r_state <= dmem_we_o ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
               if (dmem_rvalid_i) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_wb_o   <= 1'b0;
         rd_addr_wb_o <= 5'd0;
         rd_en_wb_o   <= 1'b0;
         rd_data_wb_o <= '0;
      end else begin
         if (w_wbLoad) begin
            valid_wb_o   <= 1'b1;
            rd_addr_wb_o <= w_wbAddr;
            rd_en_wb_o   <= w_wbEn;
            rd_data_wb_o <= w_wbData;
         end else if (ready_wb_i) begin
            valid_wb_o   <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_cprv_mem_stage.sv
// Self-checking bench for cprv_mem_stage: directed scenarios plus randomized traffic
// compared against a transaction-level model of the memory stage.
module tb_cprv_mem_stage;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_ALU   = 7'b0110011;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        valid_mem_i;
   logic        ready_mem_o;
   logic [63:0] alu_out_mem_i;
   logic [63:0] rs2_data_mem_i;
   logic [4:0]  rd_addr_mem_i;
   logic        rd_en_mem_i;
   logic [6:0]  opcode_mem_i;
   logic [2:0]  funct3_mem_i;
   logic        mem_w_en_mem_i;
   logic        dmem_req_o;
   logic        dmem_gnt_i;
   logic        dmem_we_o;
   logic [63:0] dmem_addr_o;
   logic [7:0]  dmem_be_o;
   logic [63:0] dmem_wdata_o;
   logic        dmem_rvalid_i;
   logic [63:0] dmem_rdata_i;
   logic        valid_wb_o;
   logic        ready_wb_i;
   logic [4:0]  rd_addr_wb_o;
   logic        rd_en_wb_o;
   logic [63:0] rd_data_wb_o;

   int numChecks = 0;
   int numFails  = 0;

   typedef struct {
      logic [63:0] data;
      logic [4:0]  rd;
      logic        en;
      bit          chkRd;
   } beat_t;

   // Model: writeback beats in flight plus the single outstanding memory access.
   beat_t       wbQ[$];
   bit          memPending = 0;
   bit          granted    = 0;
   logic [63:0] pAddr;
   logic [63:0] pWdata;
   logic [7:0]  pBe;
   bit          pWe;
   logic [2:0]  pF3;
   int          pOff;
   logic [4:0]  pRd;
   logic        pEn;

   cprv_mem_stage #(.DATA_WIDTH(64), .ADDR_WIDTH(64)) dut (
      .clk(clk), .rst(rst),
      .valid_mem_i(valid_mem_i), .ready_mem_o(ready_mem_o),
      .alu_out_mem_i(alu_out_mem_i), .rs2_data_mem_i(rs2_data_mem_i),
      .rd_addr_mem_i(rd_addr_mem_i), .rd_en_mem_i(rd_en_mem_i),
      .opcode_mem_i(opcode_mem_i), .funct3_mem_i(funct3_mem_i),
      .mem_w_en_mem_i(mem_w_en_mem_i),
      .dmem_req_o(dmem_req_o), .dmem_gnt_i(dmem_gnt_i), .dmem_we_o(dmem_we_o),
      .dmem_addr_o(dmem_addr_o), .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
      .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
      .valid_wb_o(valid_wb_o), .ready_wb_i(ready_wb_i),
      .rd_addr_wb_o(rd_addr_wb_o), .rd_en_wb_o(rd_en_wb_o), .rd_data_wb_o(rd_data_wb_o)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      numChecks++;
      if (observed !== expected) begin
         numFails++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   function automatic int accessBytes(input logic [2:0] f3);
      return 1 << f3[1:0];
   endfunction

   function automatic logic [7:0] expectedBe(input logic [2:0] f3, input int off);
      logic [15:0] lanes;
      if (accessBytes(f3) == 8) return 8'hFF;
      lanes = ((16'd1 << accessBytes(f3)) - 16'd1) << off;
      return lanes[7:0];
   endfunction

   // Extract the addressed field from the returned doubleword and extend it to 64 bits.
   function automatic logic [63:0] loadValue(input logic [63:0] rdata, input int off, input logic [2:0] f3);
      logic [63:0] v;
      logic [63:0] mask;
      int          bits;
      v = rdata >> (8 * off);
      if (accessBytes(f3) == 8) return v;
      bits = 8 * accessBytes(f3);
      mask = (64'd1 << bits) - 64'd1;
      v = v & mask;
      if (!f3[2] && v[bits-1]) v = v | ~mask;
      return v;
   endfunction

   task automatic setIdleInputs();
      valid_mem_i    = 1'b0;
      alu_out_mem_i  = 64'd0;
      rs2_data_mem_i = 64'd0;
      rd_addr_mem_i  = 5'd0;
      rd_en_mem_i    = 1'b0;
      opcode_mem_i   = OP_ALU;
      funct3_mem_i   = 3'd0;
      mem_w_en_mem_i = 1'b0;
      dmem_gnt_i     = 1'b0;
      dmem_rvalid_i  = 1'b0;
      dmem_rdata_i   = 64'd0;
      ready_wb_i     = 1'b1;
   endtask

   task automatic setInstr(input logic [6:0] opc, input logic [2:0] f3, input logic [63:0] alu,
                           input logic [63:0] rs2, input logic [4:0] rd, input logic en);
      valid_mem_i    = 1'b1;
      opcode_mem_i   = opc;
      funct3_mem_i   = f3;
      alu_out_mem_i  = alu;
      rs2_data_mem_i = rs2;
      rd_addr_mem_i  = rd;
      rd_en_mem_i    = en;
      mem_w_en_mem_i = 1'b0;
   endtask

   // Called on a falling edge with inputs already driven: checks outputs, then advances one cycle.
   task automatic applyStimulus();
      bit    expReady;
      bit    isStore;
      bit    isLoad;
      beat_t b;
      #1;
      expReady = !memPending && (wbQ.size() == 0 || ready_wb_i);
      checkOutput("ready_mem_o", ready_mem_o, expReady);
      checkOutput("dmem_req_o", dmem_req_o, memPending && !granted);
      if (memPending && !granted) begin
         checkOutput("dmem_addr_o", dmem_addr_o, pAddr);
         checkOutput("dmem_be_o", dmem_be_o, pBe);
         checkOutput("dmem_we_o", dmem_we_o, pWe);
         checkOutput("dmem_wdata_o", dmem_wdata_o, pWdata);
      end
      checkOutput("valid_wb_o", valid_wb_o, wbQ.size() != 0);
      if (wbQ.size() != 0) begin
         checkOutput("rd_data_wb_o", rd_data_wb_o, wbQ[0].data);
         checkOutput("rd_en_wb_o", rd_en_wb_o, wbQ[0].en);
         if (wbQ[0].chkRd) checkOutput("rd_addr_wb_o", rd_addr_wb_o, wbQ[0].rd);
      end
      @(posedge clk);
      if (wbQ.size() != 0 && ready_wb_i) void'(wbQ.pop_front());
      if (valid_mem_i && expReady) begin
         isStore = (opcode_mem_i == OP_STORE) || mem_w_en_mem_i;
         isLoad  = !isStore && (opcode_mem_i == OP_LOAD);
         if (isStore || isLoad) begin
            memPending = 1;
            granted    = 0;
            pOff       = int'(alu_out_mem_i % 8);
            pAddr      = alu_out_mem_i - 64'(pOff);
            pBe        = expectedBe(funct3_mem_i, pOff);
            pWe        = isStore;
            pWdata     = rs2_data_mem_i << (8 * pOff);
            pF3        = funct3_mem_i;
            pRd        = rd_addr_mem_i;
            pEn        = rd_en_mem_i;
         end else begin
            b = '{alu_out_mem_i, rd_addr_mem_i, rd_en_mem_i, 1'b1};
            wbQ.push_back(b);
         end
      end else if (memPending && !granted && dmem_gnt_i) begin
         if (pWe) begin
            b = '{64'd0, pRd, 1'b0, 1'b0};
            wbQ.push_back(b);
            memPending = 0;
         end else begin
            granted = 1;
         end
      end else if (memPending && granted && dmem_rvalid_i) begin
         b = '{loadValue(dmem_rdata_i, pOff, pF3), pRd, pEn, 1'b1};
         wbQ.push_back(b);
         memPending = 0;
      end
      @(negedge clk);
   endtask

   task automatic doReset();
      rst = 1'b1;
      #1;
      checkOutput("reset valid_wb_o", valid_wb_o, 0);
      checkOutput("reset dmem_req_o", dmem_req_o, 0);
      checkOutput("reset dmem_we_o", dmem_we_o, 0);
      checkOutput("reset dmem_be_o", dmem_be_o, 0);
      checkOutput("reset dmem_addr_o", dmem_addr_o, 0);
      checkOutput("reset dmem_wdata_o", dmem_wdata_o, 0);
      checkOutput("reset rd_addr_wb_o", rd_addr_wb_o, 0);
      checkOutput("reset rd_en_wb_o", rd_en_wb_o, 0);
      checkOutput("reset rd_data_wb_o", rd_data_wb_o, 0);
      wbQ.delete();
      memPending = 0;
      granted    = 0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Load with two stalled grant cycles; optionally an ADD waits behind it.
   task automatic doLoad(input logic [2:0] f3, input logic [63:0] alu, input logic [63:0] rdata,
                         input logic [7:0] expBe, input logic [63:0] expData, input bit followAdd);
      setInstr(OP_LOAD, f3, alu, 64'd0, 5'd7, 1'b1);
      applyStimulus();
      if (followAdd) setInstr(OP_ALU, 3'd0, 64'h55, 64'd0, 5'd9, 1'b1);
      else valid_mem_i = 1'b0;
      checkOutput("load dmem_req_o", dmem_req_o, 1);
      checkOutput("load dmem_be_o", dmem_be_o, expBe);
      checkOutput("load dmem_addr_o", dmem_addr_o, alu & ~64'd7);
      repeat (2) applyStimulus();
      dmem_gnt_i = 1'b1;
      applyStimulus();
      dmem_gnt_i    = 1'b0;
      dmem_rvalid_i = 1'b1;
      dmem_rdata_i  = rdata;
      applyStimulus();
      dmem_rvalid_i = 1'b0;
      checkOutput("load valid_wb_o", valid_wb_o, 1);
      checkOutput("load rd_data_wb_o", rd_data_wb_o, expData);
      applyStimulus();
      if (followAdd) begin
         checkOutput("follow valid_wb_o", valid_wb_o, 1);
         checkOutput("follow rd_data_wb_o", rd_data_wb_o, 64'h55);
         valid_mem_i = 1'b0;
         applyStimulus();
      end
   endtask

   task automatic randomCycle();
      int kind;
      kind = int'($urandom_range(0, 2));
      valid_mem_i    = ($urandom_range(0, 9) < 7);
      alu_out_mem_i  = {$urandom, $urandom};
      rs2_data_mem_i = {$urandom, $urandom};
      rd_addr_mem_i  = 5'($urandom_range(0, 31));
      rd_en_mem_i    = 1'($urandom_range(0, 1));
      funct3_mem_i   = 3'($urandom_range(0, 7));
      mem_w_en_mem_i = 1'b0;
      opcode_mem_i   = ($urandom_range(0, 1) == 0) ? OP_ALU : 7'b0010011;
      if (kind == 1) opcode_mem_i = OP_LOAD;
      if (kind == 2) begin
         if ($urandom_range(0, 1) == 0) begin
            opcode_mem_i   = OP_STORE;
            mem_w_en_mem_i = 1'($urandom_range(0, 1));
         end else begin
            mem_w_en_mem_i = 1'b1;
         end
      end
      ready_wb_i    = ($urandom_range(0, 3) != 0);
      dmem_gnt_i    = 1'($urandom_range(0, 1));
      dmem_rvalid_i = (memPending && !granted) ? 1'b0 : ($urandom_range(0, 9) < 4);
      dmem_rdata_i  = {$urandom, $urandom};
      applyStimulus();
   endtask

   initial begin
      setIdleInputs();
      #2;
      doReset();

      // ADD forwarded to writeback one cycle after accept.
      setInstr(OP_ALU, 3'd0, 64'h1234, 64'd0, 5'd5, 1'b1);
      applyStimulus();
      valid_mem_i = 1'b0;
      checkOutput("add valid_wb_o", valid_wb_o, 1);
      checkOutput("add rd_data_wb_o", rd_data_wb_o, 64'h1234);
      checkOutput("add rd_addr_wb_o", rd_addr_wb_o, 5);
      checkOutput("add rd_en_wb_o", rd_en_wb_o, 1);
      applyStimulus();

      doLoad(3'b000, 64'h1003, 64'h00000000_80000000, 8'h08, 64'hFFFFFFFF_FFFFFF80, 0);
      doLoad(3'b100, 64'h1003, 64'h00000000_80000000, 8'h08, 64'h80, 0);

      // Word store into the upper half of a doubleword.
      setInstr(OP_STORE, 3'b010, 64'h2004, 64'hDEADBEEF, 5'd0, 1'b0);
      applyStimulus();
      valid_mem_i = 1'b0;
      checkOutput("sw dmem_we_o", dmem_we_o, 1);
      checkOutput("sw dmem_be_o", dmem_be_o, 8'hF0);
      checkOutput("sw dmem_wdata_o", dmem_wdata_o, 64'hDEADBEEF_00000000);
      dmem_gnt_i = 1'b1;
      applyStimulus();
      dmem_gnt_i = 1'b0;
      checkOutput("sw valid_wb_o", valid_wb_o, 1);
      checkOutput("sw rd_en_wb_o", rd_en_wb_o, 0);
      applyStimulus();

      // Writeback back-pressure holds the beat and blocks new work.
      ready_wb_i = 1'b0;
      setInstr(OP_ALU, 3'd0, 64'hAAAA, 64'd0, 5'd3, 1'b1);
      applyStimulus();
      setInstr(OP_ALU, 3'd0, 64'hBBBB, 64'd0, 5'd4, 1'b1);
      repeat (3) applyStimulus();
      #1;
      checkOutput("stall ready_mem_o", ready_mem_o, 0);
      checkOutput("stall rd_data_wb_o", rd_data_wb_o, 64'hAAAA);
      ready_wb_i = 1'b1;
      applyStimulus();
      valid_mem_i = 1'b0;
      checkOutput("resume rd_data_wb_o", rd_data_wb_o, 64'hBBBB);
      applyStimulus();

      // Reset while waiting for load data; the late response must vanish.
      setInstr(OP_LOAD, 3'b011, 64'h4000, 64'd0, 5'd6, 1'b1);
      applyStimulus();
      valid_mem_i = 1'b0;
      dmem_gnt_i  = 1'b1;
      applyStimulus();
      dmem_gnt_i = 1'b0;
      doReset();
      dmem_rvalid_i = 1'b1;
      dmem_gnt_i    = 1'b1;
      dmem_rdata_i  = 64'h1111_2222_3333_4444;
      applyStimulus();
      dmem_rvalid_i = 1'b0;
      dmem_gnt_i    = 1'b0;
      #1;
      checkOutput("post-reset valid_wb_o", valid_wb_o, 0);
      checkOutput("post-reset ready_mem_o", ready_mem_o, 1);
      @(negedge clk);

      doLoad(3'b011, 64'h3000, 64'h01234567_89ABCDEF, 8'hFF, 64'h01234567_89ABCDEF, 1);

      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 299) == 0) begin
            setIdleInputs();
            doReset();
         end else begin
            randomCycle();
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
      $finish;
   end

endmodule
